// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: replays a small table of I2C register transactions
// through an external byte-level master. Optional feature: I2C_SEQ_TIMEOUT_EN.
module i2c_txn_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TO_CYCLES  = 24'hFFFFFF,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_we,
  input  logic [IW-1:0]         i_cfg_idx,
  input  logic                  i_cfg_rw,
  input  logic                  i_cfg_chk,
  input  logic [REG_WIDTH-1:0]  i_cfg_reg,
  input  logic [DATA_WIDTH-1:0] i_cfg_data,
  input  logic [ADDR_WIDTH-1:0] i_cfg_dev,
  input  logic [IW:0]           i_count,
  input  logic [15:0]           i_divider,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [IW:0]           o_mismatch_cnt,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_timeout,
  output logic                  o_m_enable,
  output logic                  o_m_rw,
  output logic [DATA_WIDTH-1:0] o_m_mosi,
  output logic [REG_WIDTH-1:0]  o_m_reg_addr,
  output logic [ADDR_WIDTH-1:0] o_m_dev_addr,
  output logic [15:0]           o_m_divider,
  input  logic [DATA_WIDTH-1:0] i_m_miso,
  input  logic                  i_m_busy
);

  localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, ISSUE, ACK, WAIT, CHECK, DONE
  } state_t;

  state_t state, state_nxt;

  logic                  tbl_rw   [DEPTH];
  logic                  tbl_chk  [DEPTH];
  logic [REG_WIDTH-1:0]  tbl_reg  [DEPTH];
  logic [DATA_WIDTH-1:0] tbl_data [DEPTH];
  logic [ADDR_WIDTH-1:0] tbl_dev  [DEPTH];

  logic [IW:0]           idx, idx_nxt;
  logic [IW:0]           n, n_nxt;
  logic [IW:0]           n_clamp;
  logic [IW-1:0]         ptr;
  logic                  en_nxt, rw_nxt, done_nxt;
  logic [DATA_WIDTH-1:0] mosi_nxt, rd_nxt;
  logic [REG_WIDTH-1:0]  reg_nxt;
  logic [ADDR_WIDTH-1:0] dev_nxt;
  logic [15:0]           div_nxt;
  logic [IW:0]           mm_nxt;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TO_CYCLES - 1);
  logic [31:0] to_cnt, to_cnt_nxt;
  logic        timeout_q, timeout_nxt;
  assign o_timeout = timeout_q;
`else
  logic to_unused;
  assign to_unused = ^TO_CYCLES;
  assign o_timeout = 1'b0;
`endif

  assign ptr     = idx[IW-1:0];
  assign n_clamp = (i_count > DEPTH_L) ? DEPTH_L : i_count;
  assign o_busy  = (state != IDLE);

  // Table is plain storage: no reset, writable only while idle
  always_ff @(posedge i_clk) begin
    if (i_cfg_we && state == IDLE) begin
      tbl_rw[i_cfg_idx]   <= i_cfg_rw;
      tbl_chk[i_cfg_idx]  <= i_cfg_chk;
      tbl_reg[i_cfg_idx]  <= i_cfg_reg;
      tbl_data[i_cfg_idx] <= i_cfg_data;
      tbl_dev[i_cfg_idx]  <= i_cfg_dev;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      idx            <= '0;
      n              <= '0;
      o_done         <= 1'b0;
      o_m_enable     <= 1'b0;
      o_m_rw         <= 1'b0;
      o_m_mosi       <= '0;
      o_m_reg_addr   <= '0;
      o_m_dev_addr   <= '0;
      o_m_divider    <= 16'h0003;
      o_rd_data      <= '0;
      o_mismatch_cnt <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      to_cnt         <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      n              <= n_nxt;
      o_done         <= done_nxt;
      o_m_enable     <= en_nxt;
      o_m_rw         <= rw_nxt;
      o_m_mosi       <= mosi_nxt;
      o_m_reg_addr   <= reg_nxt;
      o_m_dev_addr   <= dev_nxt;
      o_m_divider    <= div_nxt;
      o_rd_data      <= rd_nxt;
      o_mismatch_cnt <= mm_nxt;
`ifdef I2C_SEQ_TIMEOUT_EN
      to_cnt         <= to_cnt_nxt;
      timeout_q      <= timeout_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    n_nxt     = n;
    done_nxt  = 1'b0;
    en_nxt    = o_m_enable;
    rw_nxt    = o_m_rw;
    mosi_nxt  = o_m_mosi;
    reg_nxt   = o_m_reg_addr;
    dev_nxt   = o_m_dev_addr;
    div_nxt   = o_m_divider;
    rd_nxt    = o_rd_data;
    mm_nxt    = o_mismatch_cnt;
`ifdef I2C_SEQ_TIMEOUT_EN
    to_cnt_nxt  = '0;
    timeout_nxt = timeout_q;
`endif
    case (state)
      IDLE: begin
        if (i_start) begin
          div_nxt   = i_divider;
          n_nxt     = n_clamp;
          idx_nxt   = '0;
          mm_nxt    = '0;
`ifdef I2C_SEQ_TIMEOUT_EN
          timeout_nxt = 1'b0;
`endif
          state_nxt = (n_clamp == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!i_m_busy) begin
          rw_nxt    = tbl_rw[ptr];
          mosi_nxt  = tbl_data[ptr];
          reg_nxt   = tbl_reg[ptr];
          dev_nxt   = tbl_dev[ptr];
          en_nxt    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (i_m_busy) begin
          en_nxt    = 1'b0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!i_m_busy) state_nxt = CHECK;
      end
      CHECK: begin
        if (tbl_rw[ptr]) begin
          rd_nxt = i_m_miso;
          if (tbl_chk[ptr] && i_m_miso != tbl_data[ptr])
            mm_nxt = o_mismatch_cnt + 1'b1;
        end
        idx_nxt   = idx + 1'b1;
        state_nxt = (idx + 1'b1 == n) ? DONE : ISSUE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef I2C_SEQ_TIMEOUT_EN
    // Counter restarts on every entry to ACK or WAIT
    if ((state == ACK || state == WAIT) && state_nxt == state) begin
      to_cnt_nxt = to_cnt + 1'b1;
      if (to_cnt == TO_LAST) begin
        en_nxt      = 1'b0;
        timeout_nxt = 1'b1;
        to_cnt_nxt  = '0;
        state_nxt   = DONE;
      end
    end
`endif
  end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Self-checking bench for i2c_txn_sequencer with a byte-level slave
// model and a scoreboard of expected master transactions.
module tb_i2c_txn_sequencer;
  localparam int DEPTH = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic cfg_rw = 1'b0, cfg_chk = 1'b0;
  logic [7:0] cfg_reg = '0, cfg_data = '0;
  logic [6:0] cfg_dev = '0;
  logic [IW:0] count = '0;
  logic [15:0] divider = '0;
  logic start = 1'b0;
  logic busy, done, timeout;
  logic [IW:0] mm_cnt;
  logic [7:0] rd_data;
  logic m_enable, m_rw;
  logic [7:0] m_mosi, m_reg;
  logic [6:0] m_dev;
  logic [15:0] m_div;
  logic [7:0] m_miso;
  logic m_busy;

  typedef struct packed {
    logic rw; logic chk; logic [7:0] rg; logic [7:0] data; logic [6:0] dev;
  } ent_t;

  ent_t model [DEPTH];
  ent_t exp_q [$];
  logic [7:0] mem [256];
  int checks = 0, fails = 0;
  int en_cycles = 0, done_cnt = 0;
  int lat = 3;
  bit hang = 0;

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.TO_CYCLES(100)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_rw(cfg_rw),
    .i_cfg_chk(cfg_chk), .i_cfg_reg(cfg_reg), .i_cfg_data(cfg_data),
    .i_cfg_dev(cfg_dev), .i_count(count), .i_divider(divider),
    .i_start(start), .o_busy(busy), .o_done(done),
    .o_mismatch_cnt(mm_cnt), .o_rd_data(rd_data), .o_timeout(timeout),
    .o_m_enable(m_enable), .o_m_rw(m_rw), .o_m_mosi(m_mosi),
    .o_m_reg_addr(m_reg), .o_m_dev_addr(m_dev), .o_m_divider(m_div),
    .i_m_miso(m_miso), .i_m_busy(m_busy)
  );

  always @(negedge clk) begin
    if (m_enable) en_cycles++;
    if (done) done_cnt++;
  end

  // Slave: accepts an enable, stays busy for lat cycles, then serves mem
  initial begin : slave
    ent_t e;
    logic s_rw;
    logic [7:0] s_reg, s_mosi;
    m_busy = 1'b0;
    m_miso = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && m_enable && !m_busy) begin
        s_rw = m_rw; s_reg = m_reg; s_mosi = m_mosi;
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL txn_unexpected: got rw=%0b reg=%h, required no txn",
                   m_rw, m_reg);
        end else begin
          e = exp_q.pop_front();
          if (m_rw !== e.rw || m_reg !== e.rg || m_dev !== e.dev ||
              (!e.rw && m_mosi !== e.data)) begin
            fails++;
            $display("FAIL txn_fields: got rw=%0b dev=%h reg=%h mosi=%h, required rw=%0b dev=%h reg=%h mosi=%h",
                     m_rw, m_dev, m_reg, m_mosi, e.rw, e.dev, e.rg, e.data);
          end
        end
        m_busy = 1'b1;
        repeat (lat) @(posedge clk);
        while (hang) @(posedge clk);
        #1;
        if (s_rw) m_miso = mem[s_reg];
        else mem[s_reg] = s_mosi;
        m_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no end, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic cfg(input int i, input logic rw, input logic chk,
                     input logic [7:0] rg, input logic [7:0] dat);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = i[IW-1:0]; cfg_rw = rw; cfg_chk = chk;
    cfg_reg = rg; cfg_data = dat; cfg_dev = 7'h11;
    @(negedge clk);
    cfg_we = 1'b0;
    model[i] = '{rw: rw, chk: chk, rg: rg, data: dat, dev: 7'h11};
  endtask

  task automatic start_run(input int cnt);
    int nn;
    nn = (cnt > DEPTH) ? DEPTH : cnt;
    for (int k = 0; k < nn; k++) exp_q.push_back(model[k]);
    @(negedge clk);
    count = cnt[IW:0]; divider = 16'h0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic wait_slave_idle();
    for (int c = 0; c < 200 && m_busy; c++) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst.busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL rst.done: got %b, required 0", done); end
    checks++; if (m_enable !== 1'b0) begin fails++; $display("FAIL rst.enable: got %b, required 0", m_enable); end
    checks++; if (m_div !== 16'h0003) begin fails++; $display("FAIL rst.divider: got %h, required 0003", m_div); end
    checks++; if (mm_cnt !== '0 || rd_data !== '0 || timeout !== 1'b0) begin
      fails++; $display("FAIL rst.status: got mm=%0d rd=%h to=%b, required 0 0 0", mm_cnt, rd_data, timeout); end
    checks++; if (m_mosi !== '0 || m_reg !== '0 || m_dev !== '0 || m_rw !== 1'b0) begin
      fails++; $display("FAIL rst.fields: got %h %h %h %b, required zeros", m_mosi, m_reg, m_dev, m_rw); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    int e0, d0; bit ok;
    cfg(0, 0, 0, 8'h00, 8'hDC); cfg(1, 0, 0, 8'h01, 8'hAB);
    cfg(2, 0, 0, 8'h02, 8'hEF); cfg(3, 1, 1, 8'h00, 8'hDC);
    cfg(4, 1, 1, 8'h01, 8'hAB); cfg(5, 1, 1, 8'h02, 8'hEF);
    e0 = en_cycles; d0 = done_cnt;
    start_run(6);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL wr.busy: got %b, required 1", busy); end
    wait_done(500, ok);
    checks++; if (!ok) begin fails++; $display("FAIL wr.done_wait: got no done, required done"); end
    repeat (3) @(negedge clk);
    checks++; if (en_cycles - e0 != 6) begin fails++; $display("FAIL wr.enables: got %0d, required 6", en_cycles - e0); end
    checks++; if (rd_data !== 8'hEF) begin fails++; $display("FAIL wr.rd_data: got %h, required ef", rd_data); end
    checks++; if (mm_cnt !== '0) begin fails++; $display("FAIL wr.mismatch: got %0d, required 0", mm_cnt); end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL wr.done_pulses: got %0d, required 1", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin fails++; $display("FAIL wr.txns_left: got %0d, required 0", exp_q.size()); end
    checks++; if (m_div !== 16'h0010 || busy !== 1'b0) begin fails++; $display("FAIL wr.div_busy: got %h %b, required 0010 0", m_div, busy); end
  endtask

  task automatic test_mismatch();
    int d0; bit ok;
    cfg(4, 1, 1, 8'h01, 8'h00);
    d0 = done_cnt;
    start_run(6);
    wait_done(500, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok || done_cnt - d0 != 1) begin fails++; $display("FAIL mm.done: got %0d, required 1", done_cnt - d0); end
    checks++; if (mm_cnt !== 4'd1) begin fails++; $display("FAIL mm.count: got %0d, required 1", mm_cnt); end
    checks++; if (rd_data !== 8'hEF) begin fails++; $display("FAIL mm.rd_data: got %h, required ef", rd_data); end
    cfg(4, 1, 1, 8'h01, 8'hAB);
  endtask

  task automatic test_zero_clamp();
    int e0; bit ok;
    e0 = en_cycles;
    start_run(0);
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL zero.cycle1: got done=%b busy=%b, required 0 1", done, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin fails++; $display("FAIL zero.cycle2: got done=%b, required 1", done); end
    repeat (2) @(negedge clk);
    checks++; if (en_cycles != e0) begin fails++; $display("FAIL zero.enables: got %0d, required 0", en_cycles - e0); end
    cfg(6, 0, 0, 8'h03, 8'h11); cfg(7, 0, 0, 8'h04, 8'h22);
    e0 = en_cycles;
    start_run(DEPTH + 3);
    wait_done(800, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin fails++; $display("FAIL clamp.done_wait: got no done, required done"); end
    checks++; if (en_cycles - e0 != DEPTH) begin fails++; $display("FAIL clamp.enables: got %0d, required %0d", en_cycles - e0, DEPTH); end
    checks++; if (exp_q.size() != 0 || mm_cnt !== '0) begin fails++; $display("FAIL clamp.state: got left=%0d mm=%0d, required 0 0", exp_q.size(), mm_cnt); end
    checks++; if (mem[3] !== 8'h11 || mem[4] !== 8'h22) begin fails++; $display("FAIL clamp.writes: got %h %h, required 11 22", mem[3], mem[4]); end
  endtask

  task automatic test_busy_activity();
    int e0, d0; bit ok;
    e0 = en_cycles; d0 = done_cnt;
    start_run(6);
    repeat (4) @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'd3; cfg_rw = 1'b0; cfg_chk = 1'b0;
    cfg_reg = 8'h05; cfg_data = 8'h55; start = 1'b1; count = 4'd2;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_done(500, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok || done_cnt - d0 != 1) begin fails++; $display("FAIL act.done: got %0d, required 1", done_cnt - d0); end
    checks++; if (en_cycles - e0 != 6) begin fails++; $display("FAIL act.enables: got %0d, required 6", en_cycles - e0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL act.idle: got %b, required 0", busy); end
    start_run(6);
    wait_done(500, ok);
    repeat (2) @(negedge clk);
    checks++; if (exp_q.size() != 0 || mm_cnt !== '0 || mem[5] === 8'h55) begin
      fails++; $display("FAIL act.table: got left=%0d mm=%0d reg5=%h, required 0 0 not-55", exp_q.size(), mm_cnt, mem[5]); end
  endtask

  task automatic test_reset_mid();
    int d0; bit ok;
    lat = 10;
    d0 = done_cnt;
    start_run(6);
    for (int c = 0; c < 100 && !m_enable; c++) @(negedge clk);
    @(negedge clk);
    checks++; if (m_enable !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL rmid.in_wait: got en=%b busy=%b, required 0 1", m_enable, busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || m_enable !== 1'b0) begin fails++; $display("FAIL rmid.after: got busy=%b en=%b, required 0 0", busy, m_enable); end
    checks++; if (m_div !== 16'h0003) begin fails++; $display("FAIL rmid.divider: got %h, required 0003", m_div); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (done_cnt != d0) begin fails++; $display("FAIL rmid.no_done: got %0d, required 0", done_cnt - d0); end
    exp_q.delete();
    lat = 3;
    wait_slave_idle();
    start_run(6);
    wait_done(500, ok);
    repeat (3) @(negedge clk);
    checks++; if (!ok || done_cnt - d0 != 1) begin fails++; $display("FAIL rmid.rerun_done: got %0d, required 1", done_cnt - d0); end
    checks++; if (rd_data !== 8'hEF || mm_cnt !== '0 || exp_q.size() != 0) begin
      fails++; $display("FAIL rmid.rerun: got rd=%h mm=%0d left=%0d, required ef 0 0", rd_data, mm_cnt, exp_q.size()); end
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int e0, t_k, d_k; bit ok;
    t_k = -1; d_k = -1;
    hang = 1;
    e0 = en_cycles;
    start_run(6);
    for (int c = 0; c < 100 && !m_enable; c++) @(negedge clk);
    @(negedge clk);
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (timeout && t_k < 0) t_k = k;
      if (done && d_k < 0) d_k = k;
    end
    checks++; if (t_k != 100) begin fails++; $display("FAIL to.timeout_cycle: got %0d, required 100", t_k); end
    checks++; if (d_k < 100 || d_k > 101) begin fails++; $display("FAIL to.done_cycle: got %0d, required 100..101", d_k); end
    checks++; if (en_cycles - e0 != 1 || timeout !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL to.after: got en=%0d to=%b busy=%b, required 1 1 0", en_cycles - e0, timeout, busy); end
    hang = 0;
    exp_q.delete();
    wait_slave_idle();
    start_run(6);
    wait_done(500, ok);
    checks++; if (!ok || timeout !== 1'b0 || mm_cnt !== '0) begin
      fails++; $display("FAIL to.rerun: got ok=%0b to=%b mm=%0d, required 1 0 0", ok, timeout, mm_cnt); end
  endtask
`else
  task automatic test_timeout();
    int d0; bit ok;
    hang = 1;
    d0 = done_cnt;
    start_run(1);
    repeat (300) @(negedge clk);
    checks++; if (busy !== 1'b1 || timeout !== 1'b0 || done_cnt != d0) begin
      fails++; $display("FAIL nto.hold: got busy=%b to=%b done=%0d, required 1 0 0", busy, timeout, done_cnt - d0); end
    hang = 0;
    wait_done(100, ok);
    repeat (2) @(negedge clk);
    checks++; if (!ok || done_cnt - d0 != 1 || exp_q.size() != 0) begin
      fails++; $display("FAIL nto.release: got done=%0d left=%0d, required 1 0", done_cnt - d0, exp_q.size()); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    test_reset();
    test_write_read();
    test_mismatch();
    test_zero_clamp();
    test_busy_activity();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
